// File: rtl/seq_int_alu_if.sv
// Operand/result handshake bundle for seq_int_alu.
// master drives ops and out_ready; slave returns results, flags and busy.
interface seq_int_alu_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             ofl;
   logic             err;
   logic             busy;

   modport master (
      output in_valid, alu_op, a, b, out_ready,
      input  in_ready, out_valid, c, ofl, err, busy
   );

   modport slave (
      input  in_valid, alu_op, a, b, out_ready,
      output in_ready, out_valid, c, ofl, err, busy
   );
endinterface

// File: rtl/seq_int_alu.sv
// seq_int_alu: handshaked integer ALU, iterative shift-add mul and
// restoring div. Ports: clk, rst (sync, high), bus (slave side).
module seq_int_alu #(
   parameter int WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   seq_int_alu_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] W_C = WIDTH'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           state, state_n;
   logic [SHW-1:0]   cnt, cnt_n;
   logic             fin, fin_n;
   logic [WIDTH-1:0] hi, hi_n;
   logic [WIDTH-1:0] lo, lo_n;
   logic [WIDTH-1:0] opd, opd_n;
   logic             ov, ov_n;
   logic [WIDTH-1:0] c_q, c_n;
   logic             ofl_q, ofl_n;
   logic             err_q, err_n;

   logic             acc;
   logic [WIDTH-1:0] sc_c;
   logic             sc_ofl, sc_err;
   logic [WIDTH-1:0] mag, shl_r;
   logic [WIDTH:0]   msum, dt, dd;
   logic             ge;

   assign bus.in_ready  = (state == IDLE)
                        && (!ov || bus.out_ready);
   assign acc           = bus.in_valid && bus.in_ready;
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = ov;
   assign bus.c         = c_q;
   assign bus.ofl       = ofl_q;
   assign bus.err       = err_q;

   // b is a signed shift count; negative means logical right.
   // The most-negative b negates to itself and lands in >= WIDTH.
   always_comb begin
      mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
      if (mag >= W_C)
         shl_r = '0;
      else if (bus.b[WIDTH-1])
         shl_r = bus.a >> mag;
      else
         shl_r = bus.a << mag;
   end

   always_comb begin
      sc_c   = '0;
      sc_ofl = 1'b0;
      sc_err = 1'b0;
      case (bus.alu_op)
         4'h0: sc_c = bus.a;
         4'h1: {sc_ofl, sc_c} = {1'b0, bus.a} + {1'b0, bus.b};
         4'h2: begin
            sc_c   = bus.a - bus.b;
            sc_ofl = (bus.b > bus.a);
         end
         // only reached here when the divisor is zero
         4'h4: begin
            sc_c   = '1;
            sc_err = 1'b1;
         end
         4'h9: sc_c = bus.a & bus.b;
         4'hA: sc_c = bus.a | bus.b;
         4'hB: sc_c = bus.a ^ bus.b;
         4'hC: sc_c = shl_r;
         default: sc_err = 1'b1;
      endcase
   end

   // mul: {hi,lo} holds partial product, lo starts as multiplier.
   // div: hi is the remainder, lo shifts dividend out, quotient in.
   always_comb begin
      msum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
      dt   = {hi, lo[WIDTH-1]};
      ge   = (dt >= {1'b0, opd});
      dd   = dt - {1'b0, opd};
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fin_n   = fin;
      hi_n    = hi;
      lo_n    = lo;
      opd_n   = opd;
      ov_n    = ov;
      c_n     = c_q;
      ofl_n   = ofl_q;
      err_n   = err_q;
      if (ov && bus.out_ready)
         ov_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc) begin
               cnt_n = '0;
               fin_n = 1'b0;
               hi_n  = '0;
               if (bus.alu_op == 4'h3) begin
                  state_n = MUL;
                  lo_n    = bus.b;
                  opd_n   = bus.a;
               end else if (bus.alu_op == 4'h4
                            && bus.b != '0) begin
                  state_n = DIV;
                  lo_n    = bus.a;
                  opd_n   = bus.b;
               end else begin
                  ov_n  = 1'b1;
                  c_n   = sc_c;
                  ofl_n = sc_ofl;
                  err_n = sc_err;
               end
            end
         end
         MUL, DIV: begin
            if (fin) begin
               state_n = IDLE;
               fin_n   = 1'b0;
               cnt_n   = '0;
               ov_n    = 1'b1;
               c_n     = lo;
               ofl_n   = (state == MUL) && (|hi);
               err_n   = 1'b0;
            end else begin
               cnt_n = cnt + SHW'(1);
               fin_n = (cnt == CNT_LAST);
               if (state == MUL) begin
                  hi_n = msum[WIDTH:1];
                  lo_n = {msum[0], lo[WIDTH-1:1]};
               end else begin
                  hi_n = ge ? dd[WIDTH-1:0] : dt[WIDTH-1:0];
                  lo_n = {lo[WIDTH-2:0], ge};
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         fin   <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         opd   <= '0;
         ov    <= 1'b0;
         c_q   <= '0;
         ofl_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         fin   <= fin_n;
         hi    <= hi_n;
         lo    <= lo_n;
         opd   <= opd_n;
         ov    <= ov_n;
         c_q   <= c_n;
         ofl_q <= ofl_n;
         err_q <= err_n;
      end
   end
endmodule

// File: tb/tb_seq_int_alu.sv
// Bench for seq_int_alu: scoreboard of {err,ofl,c} per accepted op.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_seq_int_alu;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [W+1:0] exp_q[$];

   seq_int_alu_if #(.WIDTH(W)) bus();

   seq_int_alu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W+1:0] model(
      input logic [3:0]   op,
      input logic [W-1:0] x,
      input logic [W-1:0] y
   );
      logic [W-1:0]   r;
      logic           o, e;
      logic [2*W-1:0] p;
      longint         sy;
      r = '0;
      o = 1'b0;
      e = 1'b0;
      case (op)
         4'h0: r = x;
         4'h1: {o, r} = {1'b0, x} + {1'b0, y};
         4'h2: begin
            r = x - y;
            o = (y > x);
         end
         4'h3: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            r = p[W-1:0];
            o = (p[2*W-1:W] != '0);
         end
         4'h4: begin
            if (y == '0) begin
               r = '1;
               e = 1'b1;
            end else begin
               r = x / y;
            end
         end
         4'h9: r = x & y;
         4'hA: r = x | y;
         4'hB: r = x ^ y;
         4'hC: begin
            sy = longint'($signed(y));
            if (sy >= 0)
               r = (sy >= W) ? '0 : x << sy;
            else
               r = (-sy >= W) ? '0 : x >> (-sy);
         end
         default: e = 1'b1;
      endcase
      return {e, o, r};
   endfunction

   task automatic drive(
      input logic [3:0]   op,
      input logic [W-1:0] x,
      input logic [W-1:0] y
   );
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.a        = x;
      bus.b        = y;
   endtask

   task automatic test_reset;
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      drive(4'h1, 16'h0001, 16'h0001);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_ov: got %b want 0", bus.out_valid);
      end
      checks++;
      if (bus.c !== 16'h0000) begin
         errors++;
         $display("FAIL rst_c: got %h want 0000", bus.c);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: got %b want 0", bus.busy);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_rdy: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_stream;
      logic [3:0]   op[3];
      logic [W-1:0] xa[3];
      logic [W-1:0] xb[3];
      logic [W+1:0] exp;
      op[0] = 4'h1; xa[0] = 16'hFFFF; xb[0] = 16'h0001;
      op[1] = 4'h2; xa[1] = 16'h0003; xb[1] = 16'h0005;
      op[2] = 4'hB; xa[2] = 16'hF0F0; xb[2] = 16'h0FF0;
      bus.out_ready = 1'b1;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (bus.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL str_ov%0d: got %b want 1",
                        i, bus.out_valid);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL str_sb%0d: got empty want entry", i);
            end else begin
               exp = exp_q.pop_front();
               if ({bus.err, bus.ofl, bus.c} !== exp) begin
                  errors++;
                  $display("FAIL str_res%0d: got %h want %h", i,
                           {bus.err, bus.ofl, bus.c}, exp);
               end
            end
         end
         if (i < 3) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL str_rdy%0d: got %b want 1",
                        i, bus.in_ready);
            end
            drive(op[i], xa[i], xb[i]);
            exp_q.push_back(model(op[i], xa[i], xb[i]));
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL str_end: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_mul;
      logic [W-1:0] xa[2];
      logic [W-1:0] xb[2];
      logic [W+1:0] exp;
      xa[0] = 16'h0100; xb[0] = 16'h0100;
      xa[1] = 16'h00FF; xb[1] = 16'h0003;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_rdy%0d: got %b want 1",
                     i, bus.in_ready);
         end
         drive(4'h3, xa[i], xb[i]);
         exp_q.push_back(model(4'h3, xa[i], xb[i]));
         for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            // a competing op while busy must be ignored
            if (k == 0) drive(4'h0, 16'hDEAD, 16'h0000);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1
                || bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL mul_busy%0d_%0d: got %b%b%b want 010",
                        i, k, bus.out_valid, bus.busy,
                        bus.in_ready);
            end
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_lat%0d: got ov=%b busy=%b want 1 0",
                     i, bus.out_valid, bus.busy);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mul_sb%0d: got empty want entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({bus.err, bus.ofl, bus.c} !== exp) begin
               errors++;
               $display("FAIL mul_res%0d: got %h want %h", i,
                        {bus.err, bus.ofl, bus.c}, exp);
            end
         end
      end
   endtask

   task automatic test_div;
      logic [W-1:0] xa[2];
      logic [W-1:0] xb[2];
      logic [W+1:0] exp;
      xa[0] = 16'h03E8; xb[0] = 16'h0007;
      xa[1] = 16'hFFFF; xb[1] = 16'h0010;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(4'h4, xa[i], xb[i]);
         exp_q.push_back(model(4'h4, xa[i], xb[i]));
         @(negedge clk);
         bus.in_valid = 1'b0;
         for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL div_busy%0d_%0d: got %b%b want 01",
                        i, k, bus.out_valid, bus.busy);
            end
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL div_lat%0d: got %b want 1",
                     i, bus.out_valid);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL div_sb%0d: got empty want entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({bus.err, bus.ofl, bus.c} !== exp) begin
               errors++;
               $display("FAIL div_res%0d: got %h want %h", i,
                        {bus.err, bus.ofl, bus.c}, exp);
            end
         end
      end
      @(negedge clk);
      drive(4'h4, 16'h1234, 16'h0000);
      exp_q.push_back(model(4'h4, 16'h1234, 16'h0000));
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL div0_lat: got ov=%b busy=%b want 1 0",
                  bus.out_valid, bus.busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL div0_sb: got empty want entry");
      end else begin
         exp = exp_q.pop_front();
         if ({bus.err, bus.ofl, bus.c} !== exp) begin
            errors++;
            $display("FAIL div0_res: got %h want %h",
                     {bus.err, bus.ofl, bus.c}, exp);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [W+1:0] exp;
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(4'hC, 16'h8001, 16'hFFFF);
      exp_q.push_back(model(4'hC, 16'h8001, 16'hFFFF));
      @(negedge clk);
      drive(4'hA, 16'h00F0, 16'h0F0F);
      exp_q.push_back(model(4'hA, 16'h00F0, 16'h0F0F));
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
             || {bus.err, bus.ofl, bus.c} !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold%0d: got ov=%b rdy=%b r=%h want 1 0 %h",
                     k, bus.out_valid, bus.in_ready,
                     {bus.err, bus.ofl, bus.c}, exp_q[0]);
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_rdy: got %b want 1", bus.in_ready);
      end
      exp = exp_q.pop_front();
      checks++;
      if ({bus.err, bus.ofl, bus.c} !== exp) begin
         errors++;
         $display("FAIL bp_res0: got %h want %h",
                  {bus.err, bus.ofl, bus.c}, exp);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_ov1: got %b want 1", bus.out_valid);
      end
      exp = exp_q.pop_front();
      checks++;
      if ({bus.err, bus.ofl, bus.c} !== exp) begin
         errors++;
         $display("FAIL bp_res1: got %h want %h",
                  {bus.err, bus.ofl, bus.c}, exp);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_shift_err;
      localparam int N = 9;
      logic [3:0]   op[N];
      logic [W-1:0] xa[N];
      logic [W-1:0] xb[N];
      logic [W+1:0] exp;
      op[0] = 4'hC; xa[0] = 16'h0001; xb[0] = 16'h0010;
      op[1] = 4'hD; xa[1] = 16'h1234; xb[1] = 16'h5678;
      op[2] = 4'hC; xa[2] = 16'h0001; xb[2] = 16'h0003;
      op[3] = 4'hC; xa[3] = 16'h8000; xb[3] = 16'h8000;
      op[4] = 4'h5; xa[4] = 16'h0001; xb[4] = 16'h0001;
      op[5] = 4'h0; xa[5] = 16'hABCD; xb[5] = 16'h0000;
      op[6] = 4'h9; xa[6] = 16'hF0F0; xb[6] = 16'hFF00;
      op[7] = 4'hC; xa[7] = 16'h0001; xb[7] = 16'h000F;
      op[8] = 4'hC; xa[8] = 16'h8000; xb[8] = 16'hFFF1;
      bus.out_ready = 1'b1;
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (bus.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL sh_ov%0d: got %b want 1",
                        i, bus.out_valid);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sh_sb%0d: got empty want entry", i);
            end else begin
               exp = exp_q.pop_front();
               if ({bus.err, bus.ofl, bus.c} !== exp) begin
                  errors++;
                  $display("FAIL sh_res%0d: got %h want %h", i,
                           {bus.err, bus.ofl, bus.c}, exp);
               end
            end
         end
         if (i < N) begin
            drive(op[i], xa[i], xb[i]);
            exp_q.push_back(model(op[i], xa[i], xb[i]));
         end else begin
            bus.in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_mid_reset;
      logic [W+1:0] exp;
      int           seen;
      int           n;
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(4'h4, 16'hFFFF, 16'h0003);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mr_abort: got busy=%b ov=%b want 0 0",
                  bus.busy, bus.out_valid);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mr_ghost: got %0d results want 0", seen);
      end
      drive(4'h4, 16'h0064, 16'h000A);
      exp_q.push_back(model(4'h4, 16'h0064, 16'h000A));
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mr_timeout: got no result want one");
      end else begin
         checks++;
         if (n != 17) begin
            errors++;
            $display("FAIL mr_lat: got %0d want 17", n);
         end
         checks++;
         exp = exp_q.pop_front();
         if ({bus.err, bus.ofl, bus.c} !== exp) begin
            errors++;
            $display("FAIL mr_res: got %h want %h",
                     {bus.err, bus.ofl, bus.c}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mr_end: got q=%0d ov=%b want 0 0",
                  exp_q.size(), bus.out_valid);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_mul();
      test_div();
      test_backpressure();
      test_shift_err();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_int_alu.md
Name: seq_int_alu

Overview:
Parametrised, handshaked successor to the combinational 16-bit datapath ALU. Keeps the same 4-bit opcode map. Integer multiply and divide become iterative, multi-cycle units so WIDTH can scale without long combinational paths. Sits between operand fetch and writeback, with valid/ready on both sides. Float opcodes are rejected with err so the separate FPU path owns them.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), internal shift-amount / iteration-counter width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept an operation this cycle
alu_op  in  4  opcode: 0 left, 1 iadd, 2 isub, 3 imul, 4 idiv, 5-8 float, 9 band, A bior, B bxor, C ishl, D-F conversions
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
c  out  WIDTH  result
ofl  out  1  overflow flag, qualified by out_valid
err  out  1  error flag, qualified by out_valid
busy  out  1  iterative operation in progress

Behaviour:
- Reset (synchronous, clk edge with rst=1): state=IDLE, out_valid=0, c=0, ofl=0, err=0, busy=0, iteration counter=0. Reset mid-operation abandons the operation; no result is produced.
- Acceptance: an op is taken on a clk edge with in_valid && in_ready. a, b and alu_op are registered internally at acceptance; later input changes have no effect.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops therefore sustain 1 op/clk.
- Output register holds c/ofl/err stable while out_valid && !out_ready. out_valid drops on the edge where out_ready=1, unless a new result loads on the same edge.
- States:
  - IDLE: single-cycle ops load the result register directly (out_valid=1 on the next edge). Op 3 goes to MUL. Op 4 with b!=0 goes to DIV; with b==0 it loads the error result directly.
  - MUL/DIV: busy=1, run exactly WIDTH iterations, then go to IDLE and load the result with out_valid=1.
- Latency (acceptance edge to out_valid high): 1 clk for single-cycle ops and divide-by-zero; WIDTH+1 clk for imul and idiv.
- Op semantics (all unsigned unless stated; ofl=err=0 unless stated):
  - left: c=a.
  - iadd: c=(a+b) mod 2^WIDTH; ofl=carry out.
  - isub: c=(a-b) mod 2^WIDTH; ofl=1 when b>a (borrow). This is new behaviour.
  - imul: shift-add over a 2*WIDTH product, one bit per clk; c=low WIDTH bits; ofl=|high WIDTH bits.
  - idiv: restoring division, one quotient bit per clk; c=floor(a/b). Remainder is discarded.
  - idiv with b==0: c=all ones, err=1, ofl=0.
  - band, bior, bxor: bitwise AND, OR, XOR.
  - ishl: b is treated as signed. b>=0 gives c=a<<b; b<0 gives a logical right shift by -b. |shift|>=WIDTH gives c=0. b=most-negative value gives c=0.
  - 5-8 and D-F: c=0, err=1, ofl=0 (unsupported here; routed to FPU).
- busy=1 only in MUL/DIV. in_valid during busy is ignored (in_ready=0).
- Simultaneous case: a result unloads and a new single-cycle op is accepted on the same edge. out_valid stays 1 and c updates to the new result.
- Stall at completion: out_valid=1 && !out_ready while an iteration would finish is impossible. Entry to MUL/DIV requires the output slot to be free, and the slot stays occupied only by this op's result.

Test Plan:
- Reset/idle: assert rst for 2 clk with in_valid=1 -> out_valid=0, c=0, busy=0, in_ready=1 after release.
- Single-cycle stream (WIDTH=16, out_ready=1): iadd FFFF+0001, isub 0003-0005, bxor F0F0^0FF0 on consecutive clks -> results 0000/ofl=1, FFFE/ofl=1, FF00/ofl=0 on three consecutive clks; in_ready held 1.
- Multiply: imul 0100*0100 -> out_valid exactly 17 clk after acceptance, c=0000, ofl=1. Then imul 00FF*0003 -> c=02FD, ofl=0. in_ready=0 and busy=1 throughout each op.
- Divide: idiv 03E8/0007 -> c=008E after 17 clk. idiv 1234/0000 -> c=FFFF, err=1, 1 clk latency.
- Backpressure: out_ready=0 after an ishl a=8001, b=FFFF (shift right 1) -> c=4000 held stable for 5 clk. in_ready=0 during the hold. Raising out_ready accepts the pending op on the same edge.
- Shift range and mid-op reset: ishl a=0001, b=0010 -> c=0. itof opcode -> err=1, c=0. rst asserted at iteration 8 of an idiv -> no out_valid; the next op completes normally.
